// File: rtl/game_pkg.sv
// Shared game constants: bomb geometry, spawn offsets, collision bit map,
// default fall speed and the LFSR step used for enemy randomness.
package game_pkg;

  localparam int BOMB_WIDTH         = 2;
  localparam int BOMB_HEIGHT        = 6;
  localparam int BOMB_SPEED_DEFAULT = 2;

  // Bomb leaves from the middle of the 16-px-tall enemy sprite's bottom edge
  localparam logic [10:0] BOMB_SPAWN_X_OFS = 11'd7;
  localparam logic [10:0] BOMB_SPAWN_Y_OFS = 11'd16;

  localparam int COLL_BOMB_PLAYER = 1;
  localparam int COLL_BOMB_SHIELD = 3;

  localparam logic [7:0] COOLDOWN_RAND_MASK = 8'h1F;

  typedef enum logic {
    BOMB_IDLE    = 1'b0,
    BOMB_FALLING = 1'b1
  } bomb_state_t;

  // Fibonacci LFSR, taps 8,6,5,4; a nonzero state never maps to zero
  function automatic logic [7:0] lfsr_advance(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

endpackage

// File: rtl/bomb_movement.sv
// One bomb slot: IDLE/FALLING state plus position; launches on request,
// falls once per frame and is retired by collision or leaving the screen.
module bomb_movement
  import game_pkg::*;
#(
  parameter int          BOMB_SPEED    = BOMB_SPEED_DEFAULT,
  parameter logic [10:0] SCREEN_BOTTOM = 11'd479
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        launch,
  input  logic [10:0] spawn_x,
  input  logic [10:0] spawn_y,
  input  logic        hit_flag,
  input  logic        draw_req,
  output logic        falling,
  output logic [10:0] bomb_x,
  output logic [10:0] bomb_y
);

  bomb_state_t state_reg, state_next;
  logic [10:0] x_reg, x_next;
  logic [10:0] y_reg, y_next;
  logic [10:0] y_moved;

  assign y_moved = y_reg + 11'(BOMB_SPEED);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg <= BOMB_IDLE;
      x_reg     <= 11'd0;
      y_reg     <= 11'd0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    case (state_reg)
      BOMB_IDLE: begin
        if (launch) begin
          state_next = BOMB_FALLING;
          x_next     = spawn_x;
          y_next     = spawn_y;
        end
      end
      BOMB_FALLING: begin
        // A hit on our own pixel wins over the frame's move
        if (hit_flag && draw_req) begin
          state_next = BOMB_IDLE;
        end else if (startOfFrame) begin
          if (y_moved > SCREEN_BOTTOM) begin
            state_next = BOMB_IDLE;
          end else begin
            y_next = y_moved;
          end
        end
      end
      default: state_next = BOMB_IDLE;
    endcase
  end

  assign falling = (state_reg == BOMB_FALLING);
  assign bomb_x  = x_reg;
  assign bomb_y  = y_reg;

endmodule

// File: rtl/square_object.sv
// Generic rectangular sprite: registered draw request when the scan pixel
// lies inside the box anchored at topLeft and the object is enabled.
module square_object #(
  parameter int OBJECT_WIDTH  = 2,
  parameter int OBJECT_HEIGHT = 6
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  input  logic        enable,
  output logic        drawingRequest
);

  logic [11:0] right_edge;
  logic [11:0] bottom_edge;
  logic        inside_x;
  logic        inside_y;

  // One extra bit so boxes near the 11-bit limit do not wrap
  assign right_edge  = {1'b0, topLeftX} + 12'(OBJECT_WIDTH);
  assign bottom_edge = {1'b0, topLeftY} + 12'(OBJECT_HEIGHT);

  assign inside_x = (pixelX >= topLeftX) && ({1'b0, pixelX} < right_edge);
  assign inside_y = (pixelY >= topLeftY) && ({1'b0, pixelY} < bottom_edge);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drawingRequest <= 1'b0;
    end else begin
      drawingRequest <= enable && inside_x && inside_y;
    end
  end

endmodule

// File: rtl/enemy_bombs.sv
// Enemy bomb pool: LFSR-paced launches into the lowest free slot, per-slot
// movement and drawing, merged draw request and player-hit pulse.
module enemy_bombs
  import game_pkg::*;
#(
  parameter int          BOMB_AMOUNT   = 4,
  parameter logic [7:0]  BOMB_COLOR    = 8'hE0,
  parameter int          BOMB_SPEED    = BOMB_SPEED_DEFAULT,
  parameter logic [7:0]  COOLDOWN_MIN  = 8'd30,
  parameter logic [10:0] SCREEN_BOTTOM = 11'd479,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        fire_enable,
  input  logic [3:0]  collision,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] shooter_X,
  input  logic [10:0] shooter_Y,
  output logic [7:0]  random_sel,
  output logic        bombDR,
  output logic [7:0]  bombRGB,
  output logic        player_hit
);

  logic [7:0] lfsr_reg, lfsr_next;
  logic [7:0] cooldown_reg, cooldown_next;
  logic       player_hit_reg, player_hit_next;

  logic [BOMB_AMOUNT-1:0] slot_falling;
  logic [BOMB_AMOUNT-1:0] slot_dr;
  logic [BOMB_AMOUNT-1:0] slot_launch;
  logic [BOMB_AMOUNT-1:0] idle_below;

  logic        hit_flag;
  logic        any_idle;
  logic        launch_ok;
  logic [10:0] spawn_x;
  logic [10:0] spawn_y;
  logic        unused_coll_bits;

  assign hit_flag         = collision[COLL_BOMB_PLAYER] | collision[COLL_BOMB_SHIELD];
  assign unused_coll_bits = collision[0] ^ collision[2];

  assign any_idle  = ~&slot_falling;
  assign launch_ok = startOfFrame && fire_enable && (cooldown_reg == 8'd0) && any_idle;
  assign spawn_x   = shooter_X + BOMB_SPAWN_X_OFS;
  assign spawn_y   = shooter_Y + BOMB_SPAWN_Y_OFS;

  genvar gi;
  generate
    for (gi = 0; gi < BOMB_AMOUNT; gi++) begin : g_slot
      logic [10:0] bomb_x;
      logic [10:0] bomb_y;
      logic        draw_en;

      // idle_below[gi]: some lower-index slot is free and takes priority
      if (gi == 0) begin : g_first
        assign idle_below[gi] = 1'b0;
      end else begin : g_rest
        assign idle_below[gi] = idle_below[gi-1] | ~slot_falling[gi-1];
      end

      assign slot_launch[gi] = launch_ok & ~slot_falling[gi] & ~idle_below[gi];
      assign draw_en         = slot_falling[gi] & (pixelY <= SCREEN_BOTTOM);

      bomb_movement #(
        .BOMB_SPEED    (BOMB_SPEED),
        .SCREEN_BOTTOM (SCREEN_BOTTOM)
      ) u_move (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .launch       (slot_launch[gi]),
        .spawn_x      (spawn_x),
        .spawn_y      (spawn_y),
        .hit_flag     (hit_flag),
        .draw_req     (slot_dr[gi]),
        .falling      (slot_falling[gi]),
        .bomb_x       (bomb_x),
        .bomb_y       (bomb_y)
      );

      square_object #(
        .OBJECT_WIDTH  (BOMB_WIDTH),
        .OBJECT_HEIGHT (BOMB_HEIGHT)
      ) u_draw (
        .clk            (clk),
        .resetN         (resetN),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .topLeftX       (bomb_x),
        .topLeftY       (bomb_y),
        .enable         (draw_en),
        .drawingRequest (slot_dr[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lfsr_reg       <= LFSR_SEED;
      cooldown_reg   <= 8'd0;
      player_hit_reg <= 1'b0;
    end else begin
      lfsr_reg       <= lfsr_next;
      cooldown_reg   <= cooldown_next;
      player_hit_reg <= player_hit_next;
    end
  end

  always_comb begin
    lfsr_next     = lfsr_reg;
    cooldown_next = cooldown_reg;
    if (startOfFrame) begin
      lfsr_next = lfsr_advance(lfsr_reg);
      // Reload uses the value published this frame, before it advances
      if (launch_ok) begin
        cooldown_next = COOLDOWN_MIN + (lfsr_reg & COOLDOWN_RAND_MASK);
      end else if (cooldown_reg != 8'd0) begin
        cooldown_next = cooldown_reg - 8'd1;
      end
    end
    player_hit_next = collision[COLL_BOMB_PLAYER] & |(slot_dr & slot_falling);
  end

  assign random_sel = lfsr_reg;
  assign bombDR     = |slot_dr;
  assign bombRGB    = BOMB_COLOR;
  assign player_hit = player_hit_reg;

endmodule
